// File: rtl/userio_spi_master_if.sv
// Control-side byte stream of the OSD SPI master: transmit handshake, abort,
// and the received-byte strobe with its first-byte qualifier.
interface userio_spi_master_if;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_valid;
  logic       tx_ready;
  logic       abort;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_first;
  logic       busy;

  modport master (
    output tx_data, tx_last, tx_valid, abort,
    input  tx_ready, rx_data, rx_valid, rx_first, busy
  );

  modport slave (
    input  tx_data, tx_last, tx_valid, abort,
    output tx_ready, rx_data, rx_valid, rx_first, busy
  );
endinterface

// File: rtl/userio_spi_master.sv
// Host-side SPI master for the OSD link: SCK idles high, data changes on the
// falling edge, MSB first, chip select held low across a whole transaction.
module userio_spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               _reset,
  userio_spi_master_if.slave ctl,
  output logic               _scs,
  output logic               sck,
  output logic               sdo,
  input  logic               sdi
);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, WAIT, GAP} state_t;

  state_t     state;
  logic [7:0] div_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] tx_shift;
  logic [6:0] rx_shift;
  logic       last_q;
  logic       first_q;
  logic       sdi_meta;
  logic       sdi_sync;
  logic       accept;
  logic       div_done;
  logic       byte_done;
  logic       abortable;
  logic       go_gap;

  assign ctl.tx_ready = (state == IDLE) || (state == WAIT);
  assign accept       = ctl.tx_valid && ctl.tx_ready;
  assign div_done     = (div_cnt == DIV_LAST);
  assign byte_done    = (state == HIGH) && div_done && (bit_cnt == 3'd7);
  assign abortable    = (state == SETUP) || (state == LOW) || (state == HIGH) || (state == WAIT);
  // A byte that completes together with abort is still reported before GAP.
  assign go_gap       = (ctl.abort && abortable) || (byte_done && last_q);

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state        <= IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      tx_shift     <= '0;
      rx_shift     <= '0;
      last_q       <= 1'b0;
      first_q      <= 1'b0;
      sdi_meta     <= 1'b0;
      sdi_sync     <= 1'b0;
      _scs         <= 1'b1;
      sck          <= 1'b1;
      sdo          <= 1'b0;
      ctl.rx_data  <= '0;
      ctl.rx_valid <= 1'b0;
      ctl.rx_first <= 1'b0;
      ctl.busy     <= 1'b0;
    end else begin
      sdi_meta     <= sdi;
      sdi_sync     <= sdi_meta;
      ctl.rx_valid <= 1'b0;
      ctl.rx_first <= 1'b0;
      div_cnt      <= div_cnt + 8'd1;
      case (state)
        IDLE: begin
          div_cnt <= '0;
          if (accept) begin
            state    <= SETUP;
            tx_shift <= ctl.tx_data;
            last_q   <= ctl.tx_last;
            first_q  <= 1'b1;
            bit_cnt  <= '0;
            _scs     <= 1'b0;
            sck      <= 1'b1;
            sdo      <= ctl.tx_data[7];
            ctl.busy <= 1'b1;
          end
        end
        SETUP: begin
          if (div_done) begin
            state   <= LOW;
            div_cnt <= '0;
            sck     <= 1'b0;
            sdo     <= tx_shift[7];
          end
        end
        LOW: begin
          if (div_done) begin
            state   <= HIGH;
            div_cnt <= '0;
            sck     <= 1'b1;
          end
        end
        HIGH: begin
          if (div_done) begin
            div_cnt  <= '0;
            tx_shift <= {tx_shift[6:0], 1'b0};
            rx_shift <= {rx_shift[5:0], sdi_sync};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state        <= WAIT;
              ctl.rx_valid <= 1'b1;
              ctl.rx_data  <= {rx_shift, sdi_sync};
              ctl.rx_first <= first_q;
              first_q      <= 1'b0;
            end else begin
              state <= LOW;
              sck   <= 1'b0;
              sdo   <= tx_shift[6];
            end
          end
        end
        WAIT: begin
          div_cnt <= '0;
          if (accept) begin
            state    <= LOW;
            tx_shift <= ctl.tx_data;
            last_q   <= ctl.tx_last;
            sck      <= 1'b0;
            sdo      <= ctl.tx_data[7];
          end
        end
        GAP: begin
          if (div_done) begin
            state    <= IDLE;
            div_cnt  <= '0;
            ctl.busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (go_gap) begin
        state   <= GAP;
        div_cnt <= '0;
        _scs    <= 1'b1;
        sck     <= 1'b1;
        sdo     <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_userio_spi_master.sv
// Directed bench for userio_spi_master: CLK_DIV=4 and CLK_DIV=3 instances,
// loopback or a behavioural OSD slave on the SPI pins.
module tb_userio_spi_master;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       sel;
  logic       loop;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_valid;
  logic       abort;
  logic       scs4, sck4, sdo4, sdi4;
  logic       scs3, sck3, sdo3, sdi3;
  logic       m_scs, m_sck, m_sdo, m_tx_ready, m_rx_valid, m_rx_first, m_busy;
  logic [7:0] m_rx_data;
  int         vectors = 0;
  int         miscompares = 0;

  userio_spi_master_if bus4();
  userio_spi_master_if bus3();

  always #5 clk = ~clk;

  assign bus4.tx_data  = tx_data;
  assign bus4.tx_last  = tx_last;
  assign bus4.tx_valid = tx_valid && !sel;
  assign bus4.abort    = abort && !sel;
  assign bus3.tx_data  = tx_data;
  assign bus3.tx_last  = tx_last;
  assign bus3.tx_valid = tx_valid && sel;
  assign bus3.abort    = abort && sel;

  userio_spi_master #(.CLK_DIV(4)) dut4 (
    .clk(clk), ._reset(reset_n), .ctl(bus4),
    ._scs(scs4), .sck(sck4), .sdo(sdo4), .sdi(sdi4)
  );
  userio_spi_master #(.CLK_DIV(3)) dut3 (
    .clk(clk), ._reset(reset_n), .ctl(bus3),
    ._scs(scs3), .sck(sck3), .sdo(sdo3), .sdi(sdi3)
  );

  assign m_scs      = sel ? scs3 : scs4;
  assign m_sck      = sel ? sck3 : sck4;
  assign m_sdo      = sel ? sdo3 : sdo4;
  assign m_tx_ready = sel ? bus3.tx_ready : bus4.tx_ready;
  assign m_rx_valid = sel ? bus3.rx_valid : bus4.rx_valid;
  assign m_rx_first = sel ? bus3.rx_first : bus4.rx_first;
  assign m_rx_data  = sel ? bus3.rx_data  : bus4.rx_data;
  assign m_busy     = sel ? bus3.busy     : bus4.busy;

  // Behavioural OSD slave: samples on rising SCK, shifts out on falling SCK.
  logic [7:0] s_ret [3] = '{8'h3C, 8'hC3, 8'h5A};
  logic [7:0] s_out;
  logic [7:0] s_in;
  logic       s_sdo = 1'b0;
  int         s_bits = 0;
  int         s_idx = 0;
  logic [7:0] s_rx[$];
  logic       sdo_bits[$];

  assign sdi4 = loop ? sdo4 : s_sdo;
  assign sdi3 = loop ? sdo3 : s_sdo;

  function automatic logic [7:0] ret_byte(input int idx);
    return (idx < 3) ? s_ret[idx] : 8'hFF;
  endfunction

  always @(negedge m_scs) begin
    s_bits = 0;
    s_idx  = 0;
    s_out  = ret_byte(0);
    s_sdo  = s_out[7];
  end

  always @(posedge m_sck) begin
    if (m_scs === 1'b0) begin
      sdo_bits.push_back(m_sdo);
      s_in  = {s_in[6:0], m_sdo};
      s_out = {s_out[6:0], 1'b0};
      s_bits++;
      if (s_bits == 8) begin
        s_rx.push_back(s_in);
        s_bits = 0;
        s_idx++;
        s_out = ret_byte(s_idx);
      end
    end
  end

  always @(negedge m_sck) begin
    if (m_scs === 1'b0) s_sdo = s_out[7];
  end

  logic [8:0] rxq[$];
  int         hiq[$];
  int         falls = 0;
  int         scs_rises = 0;
  int         hi_run = 0;
  logic       prev_sck = 1'b1;
  logic       prev_scs = 1'b1;

  always @(negedge clk) begin
    if (m_rx_valid === 1'b1) rxq.push_back({m_rx_first, m_rx_data});
    if (m_sck === 1'b1) hi_run++;
    else if (prev_sck === 1'b1) begin
      falls++;
      hiq.push_back(hi_run);
      hi_run = 0;
    end
    if (m_scs === 1'b1 && prev_scs === 1'b0) scs_rises++;
    prev_sck = m_sck;
    prev_scs = m_scs;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    rxq.delete();
    s_rx.delete();
    sdo_bits.delete();
    hiq.delete();
    falls     = 0;
    scs_rises = 0;
    hi_run    = 0;
  endtask

  // Returns just after the accepting clock edge.
  task automatic push_byte(input logic [7:0] d, input logic last, input logic keep);
    int n = 0;
    tx_data  = d;
    tx_last  = last;
    tx_valid = 1'b1;
    while (m_tx_ready !== 1'b1 && n < 500) begin
      step(1);
      n++;
    end
    vectors++;
    if (m_tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL push_ready_timeout: tx_ready=%b, required 1", m_tx_ready);
    end
    step(1);
    if (!keep) tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_busy !== 1'b0 && n < 2000) begin
      step(1);
      n++;
    end
    vectors++;
    if (m_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_timeout: busy=%b, required 0", m_busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; tx_valid = 1'b0; abort = 1'b0; sel = 1'b0; loop = 1'b1;
    tx_data = 8'h00; tx_last = 1'b0;
    step(3);
    vectors++;
    if ({m_scs, m_sck, m_sdo, m_busy} !== 4'b1100) begin
      miscompares++; $display("FAIL reset_pins: scs,sck,sdo,busy=%b, required 1100", {m_scs, m_sck, m_sdo, m_busy});
    end
    vectors++;
    if ({m_rx_valid, m_rx_first, m_rx_data} !== 10'h000) begin
      miscompares++; $display("FAIL reset_rx: valid,first,data=%h, required 000", {m_rx_valid, m_rx_first, m_rx_data});
    end
    vectors++;
    if ({scs3, sck3, sdo3, bus3.busy} !== 4'b1100) begin
      miscompares++; $display("FAIL reset_div3: scs,sck,sdo,busy=%b, required 1100", {scs3, sck3, sdo3, bus3.busy});
    end
    vectors++;
    if (m_tx_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_ready: tx_ready=%b, required 1", m_tx_ready);
    end
    reset_n = 1'b1;
    step(2);
  endtask

  task automatic test_single_byte();
    logic [7:0] v = 8'h00;
    clear_mon(); loop = 1'b1; sel = 1'b0;
    push_byte(8'hA5, 1'b1, 1'b0);
    vectors++;
    if ({m_scs, m_sdo, m_busy, m_tx_ready} !== 4'b0110) begin
      miscompares++; $display("FAIL single_start: scs,sdo,busy,ready=%b, required 0110", {m_scs, m_sdo, m_busy, m_tx_ready});
    end
    step(3);
    vectors++;
    if (m_sck !== 1'b1) begin
      miscompares++; $display("FAIL single_setup_sck: sck=%b, required 1", m_sck);
    end
    step(1);
    vectors++;
    if (m_sck !== 1'b0) begin
      miscompares++; $display("FAIL single_first_fall: sck=%b, required 0", m_sck);
    end
    step(63);
    vectors++;
    if ({m_scs, m_rx_valid} !== 2'b00) begin
      miscompares++; $display("FAIL single_pre_done: scs,rx_valid=%b, required 00", {m_scs, m_rx_valid});
    end
    step(1);
    vectors++;
    if ({m_rx_valid, m_rx_first, m_rx_data} !== 10'h3A5) begin
      miscompares++; $display("FAIL single_rx: valid,first,data=%h, required 3a5", {m_rx_valid, m_rx_first, m_rx_data});
    end
    vectors++;
    if ({m_scs, m_sck, m_sdo} !== 3'b110) begin
      miscompares++; $display("FAIL single_gap_pins: scs,sck,sdo=%b, required 110", {m_scs, m_sck, m_sdo});
    end
    step(3);
    vectors++;
    if ({m_busy, m_tx_ready} !== 2'b10) begin
      miscompares++; $display("FAIL single_gap_hold: busy,ready=%b, required 10", {m_busy, m_tx_ready});
    end
    step(1);
    vectors++;
    if ({m_busy, m_tx_ready} !== 2'b01) begin
      miscompares++; $display("FAIL single_gap_end: busy,ready=%b, required 01", {m_busy, m_tx_ready});
    end
    foreach (sdo_bits[i]) v = {v[6:0], sdo_bits[i]};
    vectors++;
    if (falls !== 8 || sdo_bits.size() !== 8) begin
      miscompares++; $display("FAIL single_edges: falls=%0d bits=%0d, required 8 8", falls, sdo_bits.size());
    end
    vectors++;
    if (v !== 8'hA5) begin
      miscompares++; $display("FAIL single_sdo_seq: got %h, required a5", v);
    end
    vectors++;
    if (rxq.size() !== 1) begin
      miscompares++; $display("FAIL single_rx_count: got %0d, required 1", rxq.size());
    end
  endtask

  task automatic test_abort_on_done();
    clear_mon(); loop = 1'b1;
    push_byte(8'h3A, 1'b0, 1'b0);
    step(67);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    vectors++;
    if ({m_rx_valid, m_rx_data} !== 9'h13A) begin
      miscompares++; $display("FAIL abort_done_rx: valid,data=%h, required 13a", {m_rx_valid, m_rx_data});
    end
    vectors++;
    if ({m_scs, m_tx_ready} !== 2'b10) begin
      miscompares++; $display("FAIL abort_done_gap: scs,ready=%b, required 10", {m_scs, m_tx_ready});
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    clear_mon(); loop = 1'b0;
    push_byte(8'h10, 1'b0, 1'b1);
    push_byte(8'h22, 1'b0, 1'b1);
    push_byte(8'h33, 1'b1, 1'b0);
    wait_idle();
    vectors++;
    if (rxq.size() !== 3) begin
      miscompares++; $display("FAIL stream_rx_count: got %0d, required 3", rxq.size());
    end
    vectors++;
    if ({rxq[0], rxq[1], rxq[2]} !== {9'h13C, 9'h0C3, 9'h05A}) begin
      miscompares++; $display("FAIL stream_rx: got %h %h %h, required 13c 0c3 05a", rxq[0], rxq[1], rxq[2]);
    end
    vectors++;
    if (s_rx.size() !== 3 || {s_rx[0], s_rx[1], s_rx[2]} !== 24'h102233) begin
      miscompares++; $display("FAIL stream_slave_rx: got %h %h %h, required 10 22 33", s_rx[0], s_rx[1], s_rx[2]);
    end
    vectors++;
    if (scs_rises !== 1 || falls !== 24) begin
      miscompares++; $display("FAIL stream_frame: scs_rises=%0d falls=%0d, required 1 24", scs_rises, falls);
    end
    vectors++;
    if (hiq.size() < 9 || hiq[1] !== 4 || hiq[8] !== 5) begin
      miscompares++; $display("FAIL stream_sck_high: in-byte=%0d boundary=%0d, required 4 5", hiq[1], hiq[8]);
    end
  endtask

  task automatic test_stall();
    int   n = 0;
    logic ok = 1'b1;
    clear_mon(); loop = 1'b0;
    push_byte(8'h10, 1'b0, 1'b0);
    while (!(m_tx_ready === 1'b1 && m_busy === 1'b1) && n < 500) begin
      step(1);
      n++;
    end
    repeat (50) begin
      step(1);
      if (m_sck !== 1'b1 || m_scs !== 1'b0) ok = 1'b0;
    end
    vectors++;
    if (ok !== 1'b1 || m_tx_ready !== 1'b1) begin
      miscompares++; $display("FAIL stall_hold: steady=%b ready=%b, required 1 1", ok, m_tx_ready);
    end
    vectors++;
    if (rxq.size() !== 1) begin
      miscompares++; $display("FAIL stall_rx_count_mid: got %0d, required 1", rxq.size());
    end
    push_byte(8'h22, 1'b1, 1'b0);
    wait_idle();
    vectors++;
    if (rxq.size() !== 2 || rxq[1] !== 9'h0C3) begin
      miscompares++; $display("FAIL stall_rx: count=%0d second=%h, required 2 0c3", rxq.size(), rxq[1]);
    end
    vectors++;
    if ({s_rx[0], s_rx[1]} !== 16'h1022) begin
      miscompares++; $display("FAIL stall_slave_rx: got %h %h, required 10 22", s_rx[0], s_rx[1]);
    end
    vectors++;
    if (scs_rises !== 1 || falls !== 16) begin
      miscompares++; $display("FAIL stall_glitch: scs_rises=%0d falls=%0d, required 1 16", scs_rises, falls);
    end
  endtask

  task automatic test_abort();
    clear_mon(); loop = 1'b1;
    push_byte(8'h10, 1'b0, 1'b1);
    push_byte(8'h22, 1'b0, 1'b0);
    step(25);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    vectors++;
    if ({m_scs, m_sck, m_sdo, m_tx_ready} !== 4'b1100) begin
      miscompares++; $display("FAIL abort_pins: scs,sck,sdo,ready=%b, required 1100", {m_scs, m_sck, m_sdo, m_tx_ready});
    end
    step(3);
    vectors++;
    if (m_busy !== 1'b1) begin
      miscompares++; $display("FAIL abort_busy_hold: busy=%b, required 1", m_busy);
    end
    step(1);
    vectors++;
    if (m_busy !== 1'b0) begin
      miscompares++; $display("FAIL abort_busy_clear: busy=%b, required 0", m_busy);
    end
    vectors++;
    if (rxq.size() !== 1 || rxq[0] !== 9'h110) begin
      miscompares++; $display("FAIL abort_rx: count=%0d first=%h, required 1 110", rxq.size(), rxq[0]);
    end
  endtask

  task automatic test_reset_mid();
    clear_mon(); loop = 1'b1;
    push_byte(8'h5A, 1'b1, 1'b0);
    step(29);
    vectors++;
    if ({m_scs, m_sck, m_sdo} !== 3'b001) begin
      miscompares++; $display("FAIL midreset_pre: scs,sck,sdo=%b, required 001", {m_scs, m_sck, m_sdo});
    end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({m_scs, m_sck, m_sdo, m_busy, m_rx_valid} !== 5'b11000) begin
      miscompares++; $display("FAIL midreset_async: scs,sck,sdo,busy,rx_valid=%b, required 11000", {m_scs, m_sck, m_sdo, m_busy, m_rx_valid});
    end
    step(2);
    reset_n = 1'b1;
    step(1);
    vectors++;
    if (rxq.size() !== 0) begin
      miscompares++; $display("FAIL midreset_no_rx: got %0d, required 0", rxq.size());
    end
    clear_mon(); loop = 1'b0;
    push_byte(8'h77, 1'b1, 1'b0);
    wait_idle();
    vectors++;
    if (rxq.size() !== 1 || rxq[0] !== 9'h13C || s_rx[0] !== 8'h77) begin
      miscompares++; $display("FAIL midreset_resume: count=%0d rx=%h slave=%h, required 1 13c 77", rxq.size(), rxq[0], s_rx[0]);
    end
  endtask

  task automatic test_div3();
    sel = 1'b1; clear_mon(); loop = 1'b0;
    push_byte(8'h81, 1'b0, 1'b1);
    step(2);
    vectors++;
    if (m_sck !== 1'b1) begin
      miscompares++; $display("FAIL div3_setup_sck: sck=%b, required 1", m_sck);
    end
    step(1);
    vectors++;
    if ({m_scs, m_sck} !== 2'b00) begin
      miscompares++; $display("FAIL div3_first_fall: scs,sck=%b, required 00", {m_scs, m_sck});
    end
    push_byte(8'h42, 1'b1, 1'b0);
    wait_idle();
    vectors++;
    if (rxq.size() !== 2 || {rxq[0], rxq[1]} !== {9'h13C, 9'h0C3}) begin
      miscompares++; $display("FAIL div3_rx: count=%0d got %h %h, required 2 13c 0c3", rxq.size(), rxq[0], rxq[1]);
    end
    vectors++;
    if ({s_rx[0], s_rx[1]} !== 16'h8142) begin
      miscompares++; $display("FAIL div3_slave_rx: got %h %h, required 81 42", s_rx[0], s_rx[1]);
    end
    vectors++;
    if (hiq.size() < 9 || hiq[8] !== 4) begin
      miscompares++; $display("FAIL div3_boundary_high: got %0d, required 4", hiq[8]);
    end
    sel = 1'b0;
    step(2);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_abort_on_done();
    test_back_to_back();
    test_stall();
    test_abort();
    test_reset_mid();
    test_div3();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
